// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               controller between a load/store unit and main memory. Holds
//               tag/valid/data storage and a blocking miss FSM that refills a
//               whole line word by word on a read miss.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   cpu_req_i    CPU access request, fields held stable until cpu_ready_o
//   cpu_we_i     1 = store, 0 = load
//   cpu_addr_i   byte address (bits [1:0] ignored, word accesses only)
//   cpu_wdata_i  store data
//   cpu_rdata_o  load data, valid when cpu_ready_o && !cpu_we_i
//   cpu_ready_o  access completes this cycle (combinational)
//   mem_req_o    memory request, held until mem_ready_i
//   mem_we_o     1 = memory write, 0 = memory read
//   mem_addr_o   word-aligned memory byte address
//   mem_wdata_o  memory write data
//   mem_rdata_i  memory read data, valid with mem_ready_i
//   mem_ready_i  memory transfer done this cycle
// ============================================================================
module dcache_controller #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);

    localparam int OB    = $clog2(WORDS_PER_LINE);
    localparam int IB    = $clog2(NUM_LINES);
    localparam int TAG_W = 30 - OB - IB;
    localparam logic [OB-1:0] LAST_WORD = OB'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE          = 2'd0,
        S_REFILL        = 2'd1,
        S_WRITE_THROUGH = 2'd2
    } state_e;

    state_e               state_q;
    logic [OB-1:0]        cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][WORDS_PER_LINE];

    // Address decomposition of the (held) CPU address
    logic [OB-1:0]    addr_off;
    logic [IB-1:0]    addr_idx;
    logic [TAG_W-1:0] addr_tag;
    logic             unused_addr_lsbs;

    assign addr_off         = cpu_addr_i[OB+1:2];
    assign addr_idx         = cpu_addr_i[OB+IB+1:OB+2];
    assign addr_tag         = cpu_addr_i[31:OB+IB+2];
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    logic hit;
    logic rd_hit;
    logic wt_done;
    logic refill_beat;
    logic refill_last;

    assign hit         = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    assign rd_hit      = (state_q == S_IDLE) && cpu_req_i && !cpu_we_i && hit;
    assign wt_done     = (state_q == S_WRITE_THROUGH) && mem_ready_i;
    assign refill_beat = (state_q == S_REFILL) && mem_ready_i;
    assign refill_last = refill_beat && (cnt_q == LAST_WORD);

    // CPU side: hits answer in the request cycle, stores on the memory ack
    assign cpu_ready_o = rd_hit || wt_done;
    assign cpu_rdata_o = rd_hit ? data_q[addr_idx][addr_off] : 32'h0;

    // Memory side: all fields derive from registered state and the held CPU
    // request, so they stay constant while waiting for mem_ready_i.
    assign mem_req_o   = (state_q != S_IDLE);
    assign mem_we_o    = (state_q == S_WRITE_THROUGH);
    assign mem_addr_o  = (state_q == S_REFILL) ? {cpu_addr_i[31:OB+2], cnt_q, 2'b00}
                                               : {cpu_addr_i[31:2], 2'b00};
    assign mem_wdata_o = cpu_wdata_i;

    // Control FSM: state, refill word counter and valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i) begin
                        if (cpu_we_i) begin
                            state_q <= S_WRITE_THROUGH;
                        end else if (!hit) begin
                            // Line is invalid while it is being overwritten
                            state_q           <= S_REFILL;
                            cnt_q             <= '0;
                            valid_q[addr_idx] <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ready_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_WORD) begin
                            valid_q[addr_idx] <= 1'b1;
                            state_q           <= S_IDLE;
                        end
                    end
                end
                S_WRITE_THROUGH: begin
                    if (mem_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage are not reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (refill_beat) begin
                data_q[addr_idx][cnt_q] <= mem_rdata_i;
            end
            if (refill_last) begin
                tag_q[addr_idx] <= addr_tag;
            end
            // Write hit updates the cached copy; write miss does not allocate
            if (wt_done && hit) begin
                data_q[addr_idx][addr_off] <= cpu_wdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_controller
// Description : Self-checking bench for dcache_controller. A memory responder
//               with programmable wait states serves the DUT; a reference model
//               of memory contents and resident lines predicts load data,
//               latency and the memory transactions of every access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;

    localparam int NL = 8;
    localparam int WPL = 4;
    localparam int unsigned LINE_BYTES = WPL * 4;
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    dcache_controller #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_ready_o (cpu_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready)
    );

    // ---------------- main memory responder ----------------
    logic [31:0] mem_arr [1024];
    int          wcnt = 0;
    int          mem_wait = 0;
    logic        init_mem;

    assign mem_ready = mem_req && (wcnt == mem_wait);
    assign mem_rdata = mem_arr[mem_addr[11:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'h100 + 32'(i);
        end else if (mem_req && mem_ready && mem_we) begin
            mem_arr[mem_addr[11:2]] <= mem_wdata;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [1024];
    bit          m_valid [NL];
    int unsigned m_tag   [NL];

    int          assertions = 0;
    int          failures   = 0;
    int          last_cycles;
    logic [31:0] last_rdata;

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    // One CPU access; called at posedge+1, returns at posedge+1 with cpu_req
    // low so a following call issues a back-to-back request.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int          line;
        int unsigned tagv;
        bit          resident;
        int          exp_cycles;
        int          n_txn;
        logic [31:0] exp_addr [$];
        logic [31:0] exp_rdata;
        int          txn_i;
        int          n;
        bit          done;

        line      = int'((addr / LINE_BYTES) % NL);
        tagv      = addr / (LINE_BYTES * NL);
        resident  = m_valid[line] && (m_tag[line] == tagv);
        exp_rdata = ref_mem[addr[11:2]];
        if (we) begin
            n_txn = 1;
            exp_addr.push_back({addr[31:2], 2'b00});
            exp_cycles = mem_wait + 1;
        end else if (resident) begin
            n_txn = 0;
            exp_cycles = 0;
        end else begin
            n_txn = WPL;
            for (int k = 0; k < WPL; k++)
                exp_addr.push_back(32'((addr / LINE_BYTES) * LINE_BYTES + 32'(4 * k)));
            exp_cycles = WPL * (mem_wait + 1) + 1;
        end

        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        txn_i = 0; n = 0; done = 1'b0;
        while (!done && n < BUDGET) begin
            @(negedge clk);
            if (n == 0) begin
                assertions++;
                if (mem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_mem_req addr=%h: got mem_req=%b expected 0", addr, mem_req);
                end
            end else if (mem_req === 1'b1) begin
                assertions++;
                if (txn_i >= n_txn) begin
                    failures++;
                    $display("FAIL extra_mem_req addr=%h cycle=%0d: got mem_addr=%h expected no request",
                             addr, n, mem_addr);
                end else begin
                    if (mem_we !== we || mem_addr !== exp_addr[txn_i] || (we && mem_wdata !== wdata)) begin
                        failures++;
                        $display("FAIL mem_txn addr=%h cycle=%0d: got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                 addr, n, mem_we, mem_addr, mem_wdata, we, exp_addr[txn_i], wdata);
                    end
                    if (mem_ready) txn_i++;
                end
            end
            if (cpu_ready === 1'b1) begin
                done = 1'b1;
                last_cycles = n;
                last_rdata  = cpu_rdata;
                assertions++;
                if (n != exp_cycles) begin
                    failures++;
                    $display("FAIL latency addr=%h we=%b: got %0d cycles expected %0d", addr, we, n, exp_cycles);
                end
                assertions++;
                if (txn_i != n_txn) begin
                    failures++;
                    $display("FAIL txn_count addr=%h: got %0d expected %0d", addr, txn_i, n_txn);
                end
                if (!we) begin
                    assertions++;
                    if (cpu_rdata !== exp_rdata) begin
                        failures++;
                        $display("FAIL load_data addr=%h: got %h expected %h", addr, cpu_rdata, exp_rdata);
                    end
                end
            end else begin
                @(posedge clk);
                n++;
            end
        end
        if (!done) begin
            assertions++;
            failures++;
            last_cycles = -1;
            $display("FAIL timeout addr=%h: got no cpu_ready expected ready within %0d cycles", addr, BUDGET);
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        if (we) begin
            ref_mem[addr[11:2]] = wdata;
        end else if (!resident) begin
            m_valid[line] = 1'b1;
            m_tag[line]   = tagv;
        end
    endtask

    task automatic check_const(input string name, input int got, input int exp);
        assertions++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got, exp, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; init_mem = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h100 + 32'(i);
        model_reset();
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'h10;
        @(negedge clk);
        assertions++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got mem_req=%b cpu_ready=%b rdata=%h expected 0 0 0",
                     mem_req, cpu_ready, cpu_rdata);
        end
        @(posedge clk);
        #1 rst = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        assertions++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got mem_req=%b cpu_ready=%b expected 0 0", mem_req, cpu_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_read_miss();
        access(1'b0, 32'h10, 32'h0);
        check_const("miss_latency", last_cycles, 5);
        check_const("miss_rdata", int'(last_rdata), 32'h104);
        access(1'b0, 32'h1C, 32'h0);
        check_const("hit_latency", last_cycles, 0);
        check_const("hit_rdata", int'(last_rdata), 32'h107);
    endtask

    task automatic test_write_hit();
        access(1'b1, 32'h14, 32'hDEAD_BEEF);
        check_const("store_latency", last_cycles, 1);
        access(1'b0, 32'h14, 32'h0);
        check_const("store_hit_latency", last_cycles, 0);
        check_const("store_hit_rdata", int'(last_rdata), int'(32'hDEAD_BEEF));
    endtask

    task automatic test_write_miss();
        access(1'b1, 32'h200, 32'h1234_5678);
        access(1'b0, 32'h200, 32'h0);
        check_const("no_allocate_latency", last_cycles, 5);
        check_const("no_allocate_rdata", int'(last_rdata), 32'h1234_5678);
    endtask

    task automatic test_conflict();
        access(1'b0, 32'h10, 32'h0);
        check_const("resident_again", last_cycles, 0);
        access(1'b0, 32'h90, 32'h0);
        check_const("evict_latency", last_cycles, 5);
        access(1'b0, 32'h10, 32'h0);
        check_const("evicted_reload_latency", last_cycles, 5);
        access(1'b0, 32'h14, 32'h0);
        check_const("reload_written_word", int'(last_rdata), int'(32'hDEAD_BEEF));
    endtask

    task automatic test_wait_states();
        mem_wait = 3;
        access(1'b0, 32'h300, 32'h0);
        check_const("wait_miss_latency", last_cycles, 17);
        access(1'b1, 32'h304, 32'hCAFE_0001);
        check_const("wait_store_latency", last_cycles, 4);
        mem_wait = 0;
    endtask

    task automatic test_reset_mid_refill();
        mem_wait = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            assertions++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h40 + 32'(4 * k)) begin
                failures++;
                $display("FAIL partial_refill word%0d: got req=%b addr=%h expected 1 %h",
                         k, mem_req, mem_addr, 32'h40 + 32'(4 * k));
            end
        end
        @(posedge clk);
        #1 rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        assertions++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL abandon_refill: got mem_req=%b cpu_ready=%b rdata=%h expected 0 0 0",
                     mem_req, cpu_ready, cpu_rdata);
        end
        @(posedge clk);
        #1;
        access(1'b0, 32'h40, 32'h0);
        check_const("refill_after_reset_latency", last_cycles, 5);
        check_const("refill_after_reset_rdata", int'(last_rdata), 32'h110);
    endtask

    task automatic test_back_to_back();
        access(1'b0, 32'h44, 32'h0);
        access(1'b1, 32'h48, 32'hA5A5_0F0F);
        access(1'b0, 32'h48, 32'h0);
        access(1'b0, 32'h100, 32'h0);
        access(1'b0, 32'h104, 32'h0);
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] addr;
        for (int i = 0; i < 200; i++) begin
            mem_wait = $urandom_range(0, 2);
            we   = ($urandom_range(0, 2) == 0);
            addr = 32'($urandom_range(0, 255)) * 32'd4;
            access(we, addr, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        mem_wait = 0;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_wait_states();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache controller that sits between the core's load/store unit and main memory. It owns the tag/valid/data storage and a blocking miss FSM. On a read miss it refills a whole line from main memory, word by word. Every store is forwarded to main memory, and the cached copy is updated on a write hit.

## Interface

Parameters:
- NUM_LINES, 8: number of cache lines; power of two, ≥ 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- cpu_req  in  1  CPU access request; held with stable fields until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored (word accesses only).
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid only when cpu_ready && !cpu_we.
- cpu_ready  out  1  access complete this cycle (combinational).
- mem_req  out  1  main-memory request; held until mem_ready.
- mem_we  out  1  1 = memory write, 0 = memory read.
- mem_addr  out  32  word-aligned memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid when mem_ready.
- mem_ready  in  1  memory transfer done this cycle; meaningful only while mem_req = 1.

## Operation

Address split:
- Word offset is addr[OB+1:2], with OB = log2(WORDS_PER_LINE).
- Index is the next log2(NUM_LINES) bits.
- Tag is the remaining upper bits.
- hit = valid[index] && tag[index] == addr tag.

FSM states: IDLE, REFILL, WRITE_THROUGH.

IDLE:
- Read hit: cpu_ready = 1 and cpu_rdata = data[index][offset] in the same cycle; stay in IDLE.
- Read miss: go to REFILL. Clear the word counter and valid[index].
- Store, hit or miss: go to WRITE_THROUGH.
- No cpu_req: stay in IDLE; cpu_ready = 0.

REFILL:
- Drive mem_req = 1, mem_we = 0.
- mem_addr = {cpu tag, index, counter, 2'b00}, so words are fetched in order 0 to WORDS_PER_LINE-1.
- On each cycle with mem_ready: write mem_rdata into data[index][counter] and increment the counter.
- On the last word: set tag[index] and valid[index], then return to IDLE. The pending read then hits on the next cycle.

WRITE_THROUGH:
- Drive mem_req = 1, mem_we = 1, mem_addr = {cpu_addr[31:2], 2'b00}, mem_wdata = cpu_wdata.
- On mem_ready: cpu_ready = 1 in the same cycle. If the access is a hit, write cpu_wdata into data[index][offset] at that edge. Return to IDLE.
- Write miss: no allocation; cache contents are unchanged.

Memory handshake:
- The controller holds mem_addr, mem_we and mem_wdata constant while mem_req = 1 and mem_ready = 0.
- mem_req deasserts the cycle after the final mem_ready of a transaction.

cpu_ready is 0 in REFILL, and in WRITE_THROUGH whenever mem_ready = 0.

Reset, on a rising edge with rst = 1:
- All valid bits cleared, FSM to IDLE, counter to 0.
- mem_req = 0, cpu_ready = 0, cpu_rdata = 0.
- Data and tag arrays are not cleared.
- Reset during REFILL abandons the refill. The line stays invalid and mem_req is 0 from the next cycle.

## Timing

- Read hit: 0 extra cycles; cpu_ready is high in the request cycle.
- Read miss with zero-wait memory (mem_ready high whenever mem_req is high):
  - request in cycle 0;
  - mem_req in cycles 1 to WORDS_PER_LINE;
  - IDLE hit and cpu_ready in cycle WORDS_PER_LINE+1 (cycle 5 for the default).
- Each memory wait state adds one cycle.
- Store with zero-wait memory: request in cycle 0, cpu_ready in cycle 1.
- Back-to-back accesses: after cpu_ready, the CPU may present the next request in the following cycle.

## Test plan

- Reset, then load 0x0000_0010 with memory word k = 0x100+k (zero-wait) → line addresses 0x10, 0x14, 0x18, 0x1C requested in order; cpu_ready in cycle 5 with rdata 0x104; a repeat load of 0x1C hits in 0 cycles with 0x107.
- Store 0xDEAD_BEEF to 0x14 after the line is resident → mem write at 0x14, cpu_ready in cycle 1; a later load of 0x14 hits with 0xDEAD_BEEF and no mem_req.
- Store to a non-resident address 0x200 → mem write issued; a subsequent load of 0x200 misses (refill occurs), proving no allocation.
- Conflict: load 0x10, then load 0x10 + NUM_LINES×WORDS_PER_LINE×4 (0x90) → second load evicts; reloading 0x10 misses again.
- mem_ready delayed by 3 cycles per word → mem_addr and mem_req stable throughout; read-miss latency is 5 + 4×3 = 17 cycles.
- Assert rst in the middle of a refill (after 2 words) → mem_req 0 the next cycle; a following load of the same address performs a full 4-word refill.
